// File: rtl/depipe_skid_if.sv
// Valid/ready stream carrying a control field and a data field.
//   valid : producer presents an entry
//   ready : consumer can take the entry this cycle
//   ctrl  : control field (CW bits)
//   data  : data field (DW bits)
// The producer side uses the master modport and the consumer side uses the slave modport.
interface depipe_skid_if #(
    parameter int CW = 6,
    parameter int DW = 76
);
    logic          valid;
    logic          ready;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;

    modport master (output valid, output ctrl, output data, input  ready);
    modport slave  (input  valid, input  ctrl, input  data, output ready);
endinterface

// File: rtl/depipe_skid.sv
// Elastic pipeline register with a 2-entry skid buffer.
// It is placed between two pipeline stages, for example decode and execute.
// The control field is forced to zero on a flush and on a bubble, so the downstream stage sees a NOP.
// The data field is only held; reset is the only thing that clears it.
// Ports:
//   clk, rst  : clock and asynchronous active-high reset
//   flush     : synchronous kill of all held entries
//   up        : upstream stream (slave side); up.ready is driven from registers only
//   dn        : downstream stream (master side)
//   stall_cnt : saturating count of cycles with dn.valid=1 and dn.ready=0
//   flush_cnt : saturating count of flush cycles that discarded at least one valid entry
//
// state | meaning
// EMPTY | no entry held
// ONE   | main entry valid and driving dn
// FULL  | main and skid valid; upstream is back-pressured
module depipe_skid #(
    parameter int CW    = 6,
    parameter int DW    = 76,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    depipe_skid_if.slave     up,
    depipe_skid_if.master    dn,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t        state, state_nxt;
    logic [CW-1:0] main_ctrl, skid_ctrl;
    logic [DW-1:0] main_data, skid_data;
    logic          main_valid, skid_valid, in_ready;
    logic          acc_in, acc_out;
    logic          ld_main_in, ld_skid_in, ld_main_skid;

    assign main_valid = (state != EMPTY);
    assign skid_valid = (state == FULL);
    assign in_ready   = ~skid_valid;

    assign up.ready   = in_ready;
    assign dn.valid   = main_valid;
    assign dn.ctrl    = main_valid ? main_ctrl : '0;
    assign dn.data    = main_data;

    assign acc_in  = up.valid & in_ready;
    assign acc_out = main_valid & dn.ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        ld_main_in   = 1'b0;
        ld_skid_in   = 1'b0;
        ld_main_skid = 1'b0;
        if (flush) begin
            // Any input offered during the flush cycle is dropped, even when in_ready=1.
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc_in) begin
                        state_nxt  = ONE;
                        ld_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (acc_in && acc_out) begin
                        ld_main_in = 1'b1;
                    end else if (acc_in) begin
                        state_nxt  = FULL;
                        ld_skid_in = 1'b1;
                    end else if (acc_out) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (acc_out) begin
                        state_nxt    = ONE;
                        ld_main_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Control registers are cleared on a flush. Data registers keep their values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_ctrl <= '0;
            skid_ctrl <= '0;
        end else if (flush) begin
            main_ctrl <= '0;
            skid_ctrl <= '0;
        end else begin
            if (ld_main_in)        main_ctrl <= up.ctrl;
            else if (ld_main_skid) main_ctrl <= skid_ctrl;
            if (ld_skid_in)        skid_ctrl <= up.ctrl;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_data <= '0;
            skid_data <= '0;
        end else begin
            if (ld_main_in)        main_data <= up.data;
            else if (ld_main_skid) main_data <= skid_data;
            if (ld_skid_in)        skid_data <= up.data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (main_valid && !dn.ready && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_ONE;
            if (flush && main_valid && flush_cnt != '1)     flush_cnt <= flush_cnt + CNT_ONE;
        end
    end
endmodule

// File: tb/tb_depipe_skid.sv
module tb_depipe_skid;
    localparam int CW    = 6;
    localparam int DW    = 76;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    depipe_skid_if #(.CW(CW), .DW(DW)) up_if ();
    depipe_skid_if #(.CW(CW), .DW(DW)) dn_if ();

    depipe_skid #(.CW(CW), .DW(DW), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .up        (up_if),
        .dn        (dn_if),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
        up_if.valid = v;
        up_if.ctrl  = c;
        up_if.data  = d;
    endtask

    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        dn_if.ready = 1'b0;
        drive(1'b0, '0, '0);
        step();
        step();
        check("rst_out_valid", dn_if.valid, 0);
        check("rst_out_ctrl", dn_if.ctrl, 0);
        check("rst_out_data", dn_if.data, 0);
        check("rst_in_ready", up_if.ready, 1);
        check("rst_stall", stall_cnt, 0);
        rst = 1'b0;

        // Continuous flow: data 1..8 appears one cycle after it is offered, one per cycle.
        dn_if.ready = 1'b1;
        drive(1'b1, 6'h3F, 1);
        check("flow_lat0_valid", dn_if.valid, 0);
        for (int k = 1; k <= 8; k++) begin
            step();
            check("flow_valid", dn_if.valid, 1);
            check("flow_data", dn_if.data, k);
            check("flow_ctrl", dn_if.ctrl, 6'h3F);
            drive(k < 8, 6'h3F, k + 1);
        end
        step();
        check("bubble_valid", dn_if.valid, 0);
        check("bubble_ctrl", dn_if.ctrl, 0);
        check("bubble_data_hold", dn_if.data, 8);
        check("flow_stall", stall_cnt, 0);

        // Back-pressure: A is held while B goes to the skid entry and C waits upstream.
        drive(1'b1, 6'h01, 76'hA);
        step();
        check("bp_A_shown", dn_if.data, 76'hA);
        dn_if.ready = 1'b0;
        drive(1'b1, 6'h02, 76'hB);
        step();
        check("bp_full_ready", up_if.ready, 0);
        drive(1'b1, 6'h03, 76'hC);
        step();
        step();
        check("bp_A_stable", dn_if.data, 76'hA);
        check("bp_A_ctrl", dn_if.ctrl, 6'h01);
        check("bp_in_ready", up_if.ready, 0);
        check("bp_stall3", stall_cnt, 3);
        dn_if.ready = 1'b1;
        step();
        check("bp_B_data", dn_if.data, 76'hB);
        check("bp_B_ctrl", dn_if.ctrl, 6'h02);
        check("bp_B_ready", up_if.ready, 1);
        step();
        check("bp_C_data", dn_if.data, 76'hC);
        check("bp_C_ctrl", dn_if.ctrl, 6'h03);
        drive(1'b0, '0, '0);
        step();
        check("bp_empty", dn_if.valid, 0);

        // Flush while FULL, with an input offered in the same cycle.
        dn_if.ready = 1'b0;
        drive(1'b1, 6'h05, 76'hE);
        step();
        drive(1'b1, 6'h06, 76'hF);
        step();
        check("fl_full", up_if.ready, 0);
        flush = 1'b1;
        drive(1'b1, 6'h07, 76'hD);
        step();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        check("fl_valid", dn_if.valid, 0);
        check("fl_ctrl", dn_if.ctrl, 0);
        check("fl_ready", up_if.ready, 1);
        check("fl_cnt", flush_cnt, 1);
        check("fl_data_hold", dn_if.data, 76'hE);
        check("fl_stall", stall_cnt, 5);
        dn_if.ready = 1'b1;
        step();
        check("fl_D_absent", dn_if.valid, 0);

        // Flush while EMPTY changes nothing and is not counted.
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fe_valid", dn_if.valid, 0);
        check("fe_ready", up_if.ready, 1);
        check("fe_cnt", flush_cnt, 1);

        // Asynchronous reset mid-cycle while FULL.
        dn_if.ready = 1'b0;
        drive(1'b1, 6'h11, 76'h123456789);
        step();
        drive(1'b1, 6'h12, 76'h22);
        step();
        drive(1'b0, '0, '0);
        check("ar_full", up_if.ready, 0);
        #3;
        rst = 1'b1;
        #1;
        check("ar_valid", dn_if.valid, 0);
        check("ar_ctrl", dn_if.ctrl, 0);
        check("ar_data", dn_if.data, 0);
        check("ar_ready", up_if.ready, 1);
        check("ar_stall", stall_cnt, 0);
        check("ar_flush", flush_cnt, 0);
        step();
        rst = 1'b0;

        // Stall counter saturates at 15 with a 4-bit width.
        drive(1'b1, 6'h09, 76'h99);
        step();
        drive(1'b0, '0, '0);
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14) check("sat_14", stall_cnt, 14);
            if (i == 15) check("sat_15", stall_cnt, 15);
        end
        check("sat_hold", stall_cnt, 15);
        check("sat_data", dn_if.data, 76'h99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
